// File: rtl/fg_prog_sequencer.sv
// Floating-gate programming sequencer: routes one island cell through the
// row/column decoders, fires P gate-injection pulses of width W separated by
// gap G, then releases the routing. Every output comes straight from a flop.
//
// Handshake: a command is taken on the rising edge where cmd_valid && cmd_ready;
// cmd_ready is high exactly while the FSM is IDLE, including the done cycle,
// so a producer holding cmd_valid high gets back-to-back commands.
module fg_prog_sequencer #(
  parameter int NUM_COLS = 7,
  parameter int TW       = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_row,
  input  logic [3:0]    cmd_col,
  input  logic [7:0]    cmd_pulses,
  input  logic [TW-1:0] cmd_width,
  input  logic [TW-1:0] cfg_settle,
  input  logic [TW-1:0] cfg_gap,
  input  logic          abort,
  output logic [1:0]    vdec_addr,
  output logic [3:0]    hdec_addr,
  output logic          vdec_en,
  output logic          hdec_en,
  output logic          drain_sel,
  output logic          prog_sw,
  output logic          gate_pulse,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          aborted,
  output logic [7:0]    pulses_done,
  output logic [2:0]    dbg_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    PULSE   = 3'd2,
    GAP     = 3'd3,
    RELEASE = 3'd4,
    ERR     = 3'd5
  } state_t;

  localparam logic [4:0] NUM_COLS_L = 5'(NUM_COLS);

  // Phase timers count down from max(dur,1)-1 so a zero setting still gives one cycle.
  function automatic logic [TW-1:0] dur_m1(input logic [TW-1:0] x);
    dur_m1 = (x == '0) ? '0 : x - TW'(1);
  endfunction

  state_t        state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [1:0]    row_q, row_d;
  logic [3:0]    col_q, col_d;
  logic [7:0]    p_q, p_d;
  logic [TW-1:0] w_q, w_d;
  logic [7:0]    pulses_q, pulses_d;
  logic          abt_q, abt_d;
  logic          en_q, en_d;
  logic          gate_q, gate_d;
  logic          busy_q, busy_d;
  logic          ready_q, ready_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          aborted_q, aborted_d;

  logic          phase_end;
  logic          illegal_col;
  logic [8:0]    pulses_inc;

  assign phase_end   = (cnt_q == '0);
  assign illegal_col = ({1'b0, cmd_col} >= NUM_COLS_L);
  assign pulses_inc  = {1'b0, pulses_q} + 9'd1;

  // Next-state, phase timer, command latches and registered-output decode.
  always_comb begin
    state_d  = state_q;
    cnt_d    = phase_end ? cnt_q : cnt_q - TW'(1);
    row_d    = row_q;
    col_d    = col_q;
    p_d      = p_q;
    w_d      = w_q;
    pulses_d = pulses_q;
    abt_d    = abt_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          row_d    = cmd_row;
          col_d    = cmd_col;
          p_d      = cmd_pulses;
          w_d      = cmd_width;
          pulses_d = '0;
          abt_d    = 1'b0;
          if (illegal_col) begin
            state_d = ERR;
          end else begin
            state_d = SETUP;
            cnt_d   = dur_m1(cfg_settle);
          end
        end
      end
      SETUP: begin
        if (abort) begin
          state_d = RELEASE;
          cnt_d   = dur_m1(cfg_settle);
          abt_d   = 1'b1;
        end else if (phase_end) begin
          if (p_q == '0) begin
            state_d = RELEASE;
            cnt_d   = dur_m1(cfg_settle);
          end else begin
            state_d = PULSE;
            cnt_d   = dur_m1(w_q);
          end
        end
      end
      PULSE: begin
        // A pulse that reaches its last cycle is counted even if abort lands on it.
        if (phase_end) pulses_d = pulses_inc[7:0];
        if (abort) begin
          state_d = RELEASE;
          cnt_d   = dur_m1(cfg_settle);
          abt_d   = 1'b1;
        end else if (phase_end) begin
          if (pulses_inc < {1'b0, p_q}) begin
            state_d = GAP;
            cnt_d   = dur_m1(cfg_gap);
          end else begin
            state_d = RELEASE;
            cnt_d   = dur_m1(cfg_settle);
          end
        end
      end
      GAP: begin
        if (abort) begin
          state_d = RELEASE;
          cnt_d   = dur_m1(cfg_settle);
          abt_d   = 1'b1;
        end else if (phase_end) begin
          state_d = PULSE;
          cnt_d   = dur_m1(w_q);
        end
      end
      RELEASE: begin
        if (phase_end) state_d = IDLE;
      end
      ERR: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    en_d      = (state_d == SETUP) || (state_d == PULSE) || (state_d == GAP);
    gate_d    = (state_d == PULSE);
    busy_d    = (state_d != IDLE);
    ready_d   = (state_d == IDLE);
    done_d    = (state_d == IDLE) && ((state_q == RELEASE) || (state_q == ERR));
    err_d     = (state_d == IDLE) && (state_q == ERR);
    aborted_d = (state_d == IDLE) && (state_q == RELEASE) && abt_q;
  end

  // State, latches and output flops; reset clears everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      row_q     <= '0;
      col_q     <= '0;
      p_q       <= '0;
      w_q       <= '0;
      pulses_q  <= '0;
      abt_q     <= 1'b0;
      en_q      <= 1'b0;
      gate_q    <= 1'b0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      row_q     <= row_d;
      col_q     <= col_d;
      p_q       <= p_d;
      w_q       <= w_d;
      pulses_q  <= pulses_d;
      abt_q     <= abt_d;
      en_q      <= en_d;
      gate_q    <= gate_d;
      busy_q    <= busy_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      err_q     <= err_d;
      aborted_q <= aborted_d;
    end
  end

  assign cmd_ready   = ready_q;
  assign vdec_addr   = row_q;
  assign hdec_addr   = col_q;
  assign vdec_en     = en_q;
  assign hdec_en     = en_q;
  assign drain_sel   = en_q;
  assign prog_sw     = en_q;
  assign gate_pulse  = gate_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign aborted     = aborted_q;
  assign pulses_done = pulses_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_fg_prog_sequencer.sv
// Bench for fg_prog_sequencer: directed cases from the datasheet examples plus
// randomized commands, each checked cycle by cycle against a phase-list model.
module tb_fg_prog_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_row;
  logic [3:0] cmd_col;
  logic [7:0] cmd_pulses;
  logic [9:0] cmd_width;
  logic [9:0] cfg_settle;
  logic [9:0] cfg_gap;
  logic       abort;
  logic [1:0] vdec_addr;
  logic [3:0] hdec_addr;
  logic       vdec_en, hdec_en, drain_sel, prog_sw, gate_pulse;
  logic       busy, done, err, aborted;
  logic [7:0] pulses_done;
  logic [2:0] dbg_state;

  int total = 0;
  int bad   = 0;

  logic [6:0] exp_q[$];

  // Clock / reset
  always #5 clk = ~clk;

  fg_prog_sequencer dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_row(cmd_row), .cmd_col(cmd_col), .cmd_pulses(cmd_pulses),
    .cmd_width(cmd_width), .cfg_settle(cfg_settle), .cfg_gap(cfg_gap),
    .abort(abort), .vdec_addr(vdec_addr), .hdec_addr(hdec_addr),
    .vdec_en(vdec_en), .hdec_en(hdec_en), .drain_sel(drain_sel),
    .prog_sw(prog_sw), .gate_pulse(gate_pulse), .busy(busy), .done(done),
    .err(err), .aborted(aborted), .pulses_done(pulses_done),
    .dbg_state(dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Driver: present a command at the current negedge.
  task automatic start_cmd(input logic [1:0] row, input logic [3:0] col, input logic [7:0] p,
                           input logic [9:0] w, input logic [9:0] s, input logic [9:0] g);
    check("cmd_ready_before_accept", cmd_ready, 1);
    cmd_valid  = 1'b1;
    cmd_row    = row;
    cmd_col    = col;
    cmd_pulses = p;
    cmd_width  = w;
    cfg_settle = s;
    cfg_gap    = g;
  endtask

  // Builds the expected per-cycle trace from the phase rules, lets the accept
  // edge happen, then compares every cycle up to and including done.
  // Trace pack: {busy, vdec_en, hdec_en, drain_sel, prog_sw, gate_pulse, done}.
  task automatic run_cmd(input int abort_at, input bit chain);
    int s1, w1, g1, p, n, cut, exp_pulses;
    bit exp_abt, is_err;
    logic [1:0] row;
    logic [3:0] col;
    int act[$];
    logic [6:0] e, obs;
    row = cmd_row;
    col = cmd_col;
    p   = int'(cmd_pulses);
    s1  = (cfg_settle == 0) ? 1 : int'(cfg_settle);
    w1  = (cmd_width == 0) ? 1 : int'(cmd_width);
    g1  = (cfg_gap == 0) ? 1 : int'(cfg_gap);
    is_err = (int'(col) >= 7);
    exp_q.delete();
    exp_abt = 1'b0;
    exp_pulses = 0;
    if (is_err) begin
      exp_q.push_back(7'b1000000);
      exp_q.push_back(7'b0000001);
    end else begin
      for (int i = 0; i < s1; i++) act.push_back(0);
      for (int k = 1; k <= p; k++) begin
        for (int i = 0; i < w1; i++) act.push_back(1);
        if (k < p) for (int i = 0; i < g1; i++) act.push_back(0);
      end
      cut = act.size();
      exp_pulses = p;
      if (abort_at >= 1 && abort_at <= act.size()) begin
        cut = abort_at;
        exp_abt = 1'b1;
        exp_pulses = 0;
        for (int k = 1; k <= p; k++)
          if (s1 + k * w1 + (k - 1) * g1 <= abort_at) exp_pulses++;
      end
      for (int i = 0; i < cut; i++)
        exp_q.push_back(act[i] != 0 ? 7'b1111110 : 7'b1111100);
      for (int i = 0; i < s1; i++) exp_q.push_back(7'b1000000);
      exp_q.push_back(7'b0000001);
    end
    n = exp_q.size();
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int c = 1; c <= n; c++) begin
      e   = exp_q.pop_front();
      obs = {busy, vdec_en, hdec_en, drain_sel, prog_sw, gate_pulse, done};
      check($sformatf("trace_c%0d", c), 32'(obs), 32'(e));
      if (c == 1) check("pulses_cleared", pulses_done, 0);
      if (!is_err) begin
        check($sformatf("vdec_addr_c%0d", c), vdec_addr, row);
        check($sformatf("hdec_addr_c%0d", c), hdec_addr, col);
      end
      if (c == n) begin
        check("done_err", err, is_err);
        check("done_aborted", aborted, exp_abt);
        check("done_pulses", pulses_done, exp_pulses);
        check("done_ready", cmd_ready, 1);
        if (chain) return;
      end
      abort = (c == abort_at);
      @(negedge clk);
      abort = 1'b0;
    end
    check("done_one_cycle", done, 0);
    check("idle_after_done", busy, 0);
  endtask

  // Stimulus sequence
  initial begin
    int s, w, g, p, ab, act_len;
    bit ch;
    rst_n = 1'b0; cmd_valid = 1'b0; abort = 1'b0;
    cmd_row = '0; cmd_col = '0; cmd_pulses = '0; cmd_width = '0;
    cfg_settle = '0; cfg_gap = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_gate", gate_pulse, 0);
    check("rst_en", {vdec_en, hdec_en, drain_sel, prog_sw}, 0);
    check("rst_done", {done, err, aborted}, 0);
    check("rst_addr", {vdec_addr, hdec_addr}, 0);
    check("rst_pulses", pulses_done, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", cmd_ready, 1);

    // Abort while idle does nothing.
    abort = 1'b1;
    repeat (2) @(negedge clk);
    abort = 1'b0;
    check("idle_abort_busy", busy, 0);
    check("idle_abort_done", done, 0);

    // Reference example: done in cycle 19.
    start_cmd(2'd2, 4'd5, 8'd3, 10'd4, 10'd2, 10'd1);
    run_cmd(0, 1'b0);
    // No pulses: done in cycle 7.
    start_cmd(2'd1, 4'd3, 8'd0, 10'd5, 10'd3, 10'd2);
    run_cmd(0, 1'b0);
    // Illegal column, abort in ERR ignored.
    start_cmd(2'd3, 4'd9, 8'd2, 10'd2, 10'd2, 10'd2);
    run_cmd(1, 1'b0);
    // Abort mid second pulse.
    start_cmd(2'd0, 4'd6, 8'd5, 10'd4, 10'd2, 10'd1);
    run_cmd(9, 1'b0);
    // Abort on the final pulse edge.
    start_cmd(2'd1, 4'd1, 8'd2, 10'd2, 10'd1, 10'd1);
    run_cmd(6, 1'b0);
    // Abort during RELEASE ignored.
    start_cmd(2'd1, 4'd1, 8'd2, 10'd2, 10'd1, 10'd1);
    run_cmd(7, 1'b0);
    // Back-to-back with cmd_valid held.
    start_cmd(2'd3, 4'd2, 8'd1, 10'd2, 10'd1, 10'd1);
    run_cmd(0, 1'b1);
    start_cmd(2'd0, 4'd4, 8'd2, 10'd1, 10'd2, 10'd2);
    run_cmd(0, 1'b0);

    // Reset in the third PULSE cycle.
    start_cmd(2'd1, 4'd2, 8'd3, 10'd4, 10'd2, 10'd1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_reset_gate", gate_pulse, 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_gate", gate_pulse, 0);
    check("async_rst_prog_sw", prog_sw, 0);
    check("async_rst_en", {vdec_en, hdec_en, drain_sel}, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_addr", {vdec_addr, hdec_addr}, 0);
    check("async_rst_pulses", pulses_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", cmd_ready, 1);
    check("post_rst_no_done", done, 0);
    start_cmd(2'd2, 4'd3, 8'd2, 10'd2, 10'd1, 10'd2);
    run_cmd(0, 1'b0);

    // Randomized commands.
    for (int it = 0; it < 30; it++) begin
      s = $urandom_range(0, 4);
      w = $urandom_range(0, 4);
      g = $urandom_range(0, 4);
      p = $urandom_range(0, 4);
      act_len = (s == 0 ? 1 : s) * 2 + p * ((w == 0 ? 1 : w) + (g == 0 ? 1 : g));
      ab = ($urandom_range(0, 1) == 1) ? $urandom_range(1, act_len) : 0;
      ch = (it != 29) && ($urandom_range(0, 2) == 0);
      start_cmd(2'($urandom_range(0, 3)),
                4'(($urandom_range(0, 7) == 0) ? $urandom_range(7, 15) : $urandom_range(0, 6)),
                8'(p), 10'(w), 10'(s), 10'(g));
      run_cmd(ab, ch);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
